// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Execute-stage iterative multiply/divide unit. It owns the architectural
// HI/LO registers. MULT/MULTU/DIV/DIVU run for a fixed latency:
//   - one latch cycle;
//   - WIDTH iteration cycles;
//   - one sign-fixup cycle.
// The pipeline is held through stall_req while an operation runs. MTHI/MTLO
// write HI/LO in a single cycle.
//
// Ports:
//   clk        input   1      rising-edge clock
//   rst        input   1      synchronous active-high reset
//   flush      input   1      synchronous abort of any in-flight operation
//   start      input   1      EX holds a SPECIAL-opcode instruction
//   funct      input   6      instruction funct field
//   operand_1  input   WIDTH  rs value (multiplicand / dividend / MTx source)
//   operand_2  input   WIDTH  rt value (multiplier / divisor)
//   stall_req  output  1      pipeline hold request
//   done       output  1      one-cycle pulse after HI/LO took a mul/div result
//   hi         output  WIDTH  architectural HI register
//   lo         output  WIDTH  architectural LO register
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    // Shared 2*WIDTH working register:
    //   mul: {partial product, remaining multiplier bits};
    //   div: {partial remainder, dividend/quotient bits}.
    logic [2*WIDTH-1:0] acc;
    // Multiplicand for mul, divisor for div (both as magnitudes).
    logic [WIDTH-1:0]   operand_b;
    logic               neg_q;
    logic               neg_r;
    logic               is_div;

    logic               op_mul;
    logic               op_div;
    logic               op_signed;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_1;
    logic [WIDTH-1:0]   mag_2;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quo;
    logic [WIDTH-1:0]   fix_rem;

    // Instruction decode and operand magnitudes for the latch cycle.
    // Signed operations work on magnitudes; the sign is restored in FIX.
    always_comb begin
        op_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
        op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
        op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        div_zero  = (operand_2 == '0);
        mag_1     = (op_signed && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
        mag_2     = (op_signed && operand_2[WIDTH-1]) ? -operand_2 : operand_2;
    end

    // Hold the pipeline for the whole operation. This includes the cycle in
    // which the operation is first presented. HI/LO are readable again in the
    // cycle where done is high.
    always_comb begin
        stall_req = 1'b0;
        if (state != S_IDLE) begin
            stall_req = 1'b1;
        end else if (start && (op_mul || op_div)) begin
            stall_req = 1'b1;
        end
    end

    // One radix-2 shift-add step.
    // The low bit of acc is the current multiplier bit. The carry out of the
    // add shifts into the top of acc.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // One restoring-division step.
    // Shift the next dividend bit into the partial remainder, then trial-
    // subtract the divisor. A non-negative difference sets the quotient bit and
    // is kept. The shifted remainder can use WIDTH+1 bits, so the trial is done
    // at that width.
    always_comb begin
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, operand_b};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Final two's-complement fixup.
    // The quotient and remainder are negated independently of each other.
    always_comb begin
        fix_prod = neg_q ? -acc : acc;
        fix_quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Main sequencer and HI/LO ownership.
    // rst beats flush, and flush beats everything else. A flush drops the
    // operation in flight and any start in the same cycle, including MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            acc       <= '0;
            operand_b <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            is_div    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (op_mul) begin
                                acc       <= {{WIDTH{1'b0}}, mag_2};
                                operand_b <= mag_1;
                                neg_q     <= op_signed && (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                                neg_r     <= 1'b0;
                                is_div    <= 1'b0;
                                count     <= '0;
                                state     <= S_MUL;
                            end else if (op_div) begin
                                // With a zero divisor, restoring division yields
                                // an all-ones quotient and the dividend as the
                                // remainder. Latching the raw dividend with the
                                // fixup disabled makes HI the original operand_1.
                                acc       <= {{WIDTH{1'b0}}, div_zero ? operand_1 : mag_1};
                                operand_b <= mag_2;
                                neg_q     <= !div_zero && op_signed &&
                                             (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                                neg_r     <= !div_zero && op_signed && operand_1[WIDTH-1];
                                is_div    <= 1'b1;
                                count     <= '0;
                                state     <= S_DIV;
                            end else if (funct == FUNCT_MTHI) begin
                                hi <= operand_1;
                            end else if (funct == FUNCT_MTLO) begin
                                lo <= operand_1;
                            end
                        end
                    end
                    S_MUL: begin
                        acc <= mul_next;
                        if (count == LAST_ITER) begin
                            count <= '0;
                            state <= S_FIX;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    S_DIV: begin
                        acc <= div_next;
                        if (count == LAST_ITER) begin
                            count <= '0;
                            state <= S_FIX;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    S_FIX: begin
                        if (is_div) begin
                            lo <= fix_quo;
                            hi <= fix_rem;
                        end else begin
                            {hi, lo} <= fix_prod;
                        end
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed bench for mult_div_unit, with a small set of randomised ops.
// Each expected HI/LO pair goes into a queue when the operation is driven. The
// pair is popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam int         LATENCY = 34;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors;
    int          checks;
    logic [63:0] sb_q[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock with a 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's own expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference {hi,lo}, computed with plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int     q;
        int     r;
        model = '0;
        case (f)
            F_MULT: begin
                p     = longint'($signed(a)) * longint'($signed(b));
                model = p;
            end
            F_MULTU: model = {32'd0, a} * {32'd0, b};
            F_DIVU: begin
                if (b == 0) model = {a, 32'hFFFFFFFF};
                else        model = {a % b, a / b};
            end
            F_DIV: begin
                if (b == 0) begin
                    model = {a, 32'hFFFFFFFF};
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    model = {32'h0, 32'h80000000};
                end else begin
                    q     = $signed(a) / $signed(b);
                    r     = $signed(a) % $signed(b);
                    model = {r, q};
                end
            end
            default: model = '0;
        endcase
    endfunction

    // Present one instruction for exactly one edge.
    // Called at #1 after an edge, and returns at #1 after the sampling edge.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
        logic exp_stall;
        exp_stall = (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
        funct     = f;
        operand_1 = a;
        operand_2 = b;
        start     = 1'b1;
        #1;
        checkOutput({tag, "_stall_T"}, 64'(stall_req), 64'(exp_stall));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Walk forward until done, checking stall each busy cycle, then pop the
    // scoreboard. first_k is the cycle offset from T at entry.
    task automatic waitResult(input string tag, input int first_k);
        int          k;
        bit          seen;
        logic [63:0] exp;
        seen = 1'b0;
        k    = first_k;
        while (k <= LATENCY + 6) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checkOutput({tag, "_stall_busy"}, 64'(stall_req), 64'd1);
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput({tag, "_latency"}, 64'(k), 64'(LATENCY));
        if (seen) begin
            checkOutput({tag, "_stall_done"}, 64'(stall_req), 64'd0);
        end
        if (sb_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            exp = sb_q.pop_front();
            checkOutput({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
            checkOutput({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        end
    endtask

    // Full mul/div transaction with a bench-supplied expected result
    task automatic runOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
        sb_q.push_back(exp);
        applyStimulus(f, a, b, tag);
        waitResult(tag, 1);
    endtask

    // Run idle cycles and count any done pulses; none are expected
    task automatic quietCycles(input int n, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_no_done"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  fsel[4];

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        start     = 1'b0;
        funct     = 6'h00;
        operand_1 = '0;
        operand_2 = '0;
        fsel      = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_stall", 64'(stall_req), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed multiply/divide");
        runOp(F_MULT,  32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFF, 32'hFFFFFFEB}, "mult_neg3x7");
        runOp(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, "multu_max");
        runOp(F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 32'h00000001}, "mult_m1xm1");
        runOp(F_DIV,   32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_neg7by2");
        runOp(F_DIVU,  32'd7,        32'd2,        {32'h00000001, 32'h00000003}, "divu_7by2");
        runOp(F_DIV,   32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, "div_ovf");
        runOp(F_DIVU,  32'h12345678, 32'd0,        {32'h12345678, 32'hFFFFFFFF}, "divu_zero");
        runOp(F_DIV,   32'h80000001, 32'd0,        {32'h80000001, 32'hFFFFFFFF}, "div_zero_neg");

        $display("[TB] randomised multiply/divide");
        for (int i = 0; i < 6; i++) begin
            rf = fsel[$urandom_range(0, 3)];
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            runOp(rf, ra, rb, model(rf, ra, rb), "rand_op");
        end

        $display("[TB] MTHI/MTLO back to back");
        applyStimulus(F_MTHI, 32'hAAAA5555, 32'd0, "mthi");
        checkOutput("mthi_hi", 64'(hi), 64'hAAAA5555);
        checkOutput("mthi_done", 64'(done), 64'd0);
        applyStimulus(F_MTLO, 32'h00001234, 32'd0, "mtlo");
        checkOutput("mtlo_lo", 64'(lo), 64'h00001234);
        checkOutput("mtlo_hi_kept", 64'(hi), 64'hAAAA5555);
        checkOutput("mtlo_done", 64'(done), 64'd0);

        $display("[TB] undeclared funct");
        applyStimulus(6'h10, 32'hDEAD0000, 32'd1, "funct_other");
        checkOutput("funct_other_hi", 64'(hi), 64'hAAAA5555);
        checkOutput("funct_other_lo", 64'(lo), 64'h00001234);

        $display("[TB] flush mid-divide");
        applyStimulus(F_DIV, 32'd100, 32'd7, "flush_div");
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_stall_off", 64'(stall_req), 64'd0);
        quietCycles(40, "flush_div");
        checkOutput("flush_hi_kept", 64'(hi), 64'hAAAA5555);
        checkOutput("flush_lo_kept", 64'(lo), 64'h00001234);

        $display("[TB] flush discards same-cycle MTHI");
        flush = 1'b1;
        applyStimulus(F_MTHI, 32'hDEADBEEF, 32'd0, "flush_mthi");
        flush = 1'b0;
        checkOutput("flush_mthi_hi", 64'(hi), 64'hAAAA5555);

        $display("[TB] start while busy is ignored");
        sb_q.push_back({32'hFFFFFFFE, 32'h00000001});
        applyStimulus(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "busy");
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start     = 1'b1;
        funct     = F_MTHI;
        operand_1 = 32'h5A5A5A5A;
        operand_2 = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitResult("busy", 6);

        $display("[TB] reset mid-multiply");
        applyStimulus(F_MULT, 32'd3, 32'd5, "rst_mul");
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_mul_hi", 64'(hi), 64'd0);
        checkOutput("rst_mul_lo", 64'(lo), 64'd0);
        checkOutput("rst_mul_stall", 64'(stall_req), 64'd0);
        quietCycles(40, "rst_mul");
        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
